// File: rtl/simplenet_weight_loader.sv
// simpleNet weight loader: streams nine signed weights into a shadow bank
// and swaps the whole set into the active registers in one cycle.
module simplenet_weight_loader #(
    parameter int                     W_WIDTH = 4,
    parameter logic [9*W_WIDTH-1:0]   INIT_W  = 36'h1E2322122
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W_WIDTH-1:0]         in_data,
    input  logic                       in_last,
    output logic signed [W_WIDTH-1:0]  w0,
    output logic signed [W_WIDTH-1:0]  w1,
    output logic signed [W_WIDTH-1:0]  w2,
    output logic signed [W_WIDTH-1:0]  w3,
    output logic signed [W_WIDTH-1:0]  w4,
    output logic signed [W_WIDTH-1:0]  w5,
    output logic signed [W_WIDTH-1:0]  w6,
    output logic signed [W_WIDTH-1:0]  w7,
    output logic signed [W_WIDTH-1:0]  w8,
    output logic                       load_done,
    output logic                       load_err,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [W_WIDTH-1:0]   shadow_q [9];
    logic [W_WIDTH-1:0]   act_q    [9];
    logic                 done_q;
    logic                 err_q;
    logic                 accept;

    // Ready is held low while reset is asserted, even though the state is IDLE.
    assign in_ready  = !rst && (state_q != COMMIT);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign load_done = done_q;
    assign load_err  = err_q;

    assign w0 = act_q[0];
    assign w1 = act_q[1];
    assign w2 = act_q[2];
    assign w3 = act_q[3];
    assign w4 = act_q[4];
    assign w5 = act_q[5];
    assign w6 = act_q[6];
    assign w7 = act_q[7];
    assign w8 = act_q[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= INIT_W[i*W_WIDTH +: W_WIDTH];
                act_q[i]    <= INIT_W[i*W_WIDTH +: W_WIDTH];
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            err_q <= 1'b1;
                        end else begin
                            shadow_q[0] <= in_data;
                            idx_q       <= 4'd1;
                            state_q     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow_q[idx_q] <= in_data;
                        if (in_last) begin
                            if (idx_q == 4'd8) begin
                                state_q <= COMMIT;
                            end else begin
                                err_q   <= 1'b1;
                                idx_q   <= '0;
                                state_q <= IDLE;
                            end
                        end else if (idx_q == 4'd8) begin
                            state_q <= DRAIN;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                COMMIT: begin
                    act_q   <= shadow_q;
                    done_q  <= 1'b1;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                DRAIN: begin
                    // Overlong frame: swallow beats until the frame closes.
                    if (accept && in_last) begin
                        err_q   <= 1'b1;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simplenet_weight_loader.sv
// Self-checking bench for simplenet_weight_loader with a commit scoreboard.
module tb_simplenet_weight_loader;

    localparam logic [35:0] INIT = 36'h1E2322122;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_data;
    logic              in_last;
    logic signed [3:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic              load_done;
    logic              load_err;
    logic              busy;
    logic [35:0]       wimg;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [35:0] exp_q[$];
    logic [35:0] cur;

    always #5 clk = ~clk;

    simplenet_weight_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .w5(w5), .w6(w6), .w7(w7), .w8(w8),
        .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    assign wimg = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (load_done) n_done++;
            if (load_err) n_err++;
            checks++;
            if (load_done && load_err) begin
                failures++;
                $display("FAIL done_err_exclusive: both high at cyc %0d", cyc);
            end
        end
    end

    function automatic logic [35:0] fill(input logic [3:0] v);
        return {9{v}};
    endfunction

    task automatic beat(input logic [3:0] d, input logic l);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = in_ready;
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic send_frame(input logic [35:0] img, input int n,
                              input int last_at, input bit bubble);
        logic [3:0] d;
        for (int k = 0; k < n; k++) begin
            d = (k < 9) ? img[k*4 +: 4] : 4'h0;
            beat(d, k == last_at);
            if (bubble) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_evt(output bit got);
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (load_done || load_err) got = 1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready: got %0b required 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rel_ready: got %0b required 1", in_ready);
        end
        checks++;
        if (busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags: busy=%0b done=%0b err=%0b required 0",
                     busy, load_done, load_err);
        end
        checks++;
        if (wimg !== INIT) begin
            failures++;
            $display("FAIL rst_weights: got %h required %h", wimg, INIT);
        end
        checks++;
        if (w7 !== 4'b1110) begin
            failures++;
            $display("FAIL rst_w7: got %b required 1110", w7);
        end
        cur = INIT;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [35:0] img, exp;
        int c0;
        for (int k = 0; k < 9; k++) img[k*4 +: 4] = 4'(k + 1);
        exp_q.push_back(img);
        c0 = cyc;
        for (int k = 0; k < 9; k++) beat(img[k*4 +: 4], k == 8);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_commit: ready=%0b busy=%0b required 0/1",
                     in_ready, busy);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: ready=%0b done=%0b required 1/1",
                     in_ready, load_done);
        end
        exp = exp_q.pop_front();
        checks++;
        if (wimg !== exp) begin
            failures++;
            $display("FAIL b2b_weights: got %h required %h", wimg, exp);
        end
        checks++;
        if (cyc - c0 != 10) begin
            failures++;
            $display("FAIL b2b_latency: got %0d required 10", cyc - c0);
        end
        cur = exp;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulse: done=%0b required 0", load_done);
        end
    endtask

    task automatic commit_frame(input logic [35:0] img, input bit bubble,
                                input string nm);
        bit got;
        logic [35:0] exp;
        int d0;
        d0 = n_done;
        exp_q.push_back(img);
        send_frame(img, 9, 8, bubble);
        wait_evt(got);
        checks++;
        if (!got || load_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: got=%0b done=%0b required 1", nm, got,
                     load_done);
        end
        exp = exp_q.pop_front();
        checks++;
        if (wimg !== exp) begin
            failures++;
            $display("FAIL %s_weights: got %h required %h", nm, wimg, exp);
        end
        cur = exp;
        repeat (2) @(negedge clk);
        checks++;
        if (n_done != d0 + 1) begin
            failures++;
            $display("FAIL %s_count: got %0d required %0d", nm, n_done - d0, 1);
        end
    endtask

    task automatic test_bubbled;
        commit_frame(fill(4'hF), 1'b1, "bubble");
    endtask

    task automatic test_short;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send_frame(fill(4'h3), 5, 4, 1'b0);
        checks++;
        if (load_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL short_err: err=%0b busy=%0b required 1/0",
                     load_err, busy);
        end
        @(negedge clk);
        checks++;
        if (wimg !== cur || n_done != d0 || n_err != e0 + 1) begin
            failures++;
            $display("FAIL short_state: w=%h dn=%0d er=%0d required %h 0 1",
                     wimg, n_done - d0, n_err - e0, cur);
        end
        commit_frame(36'h5A3C96E10, 1'b0, "after_short");
    endtask

    task automatic test_long;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send_frame(fill(4'h6), 12, 11, 1'b0);
        checks++;
        if (load_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL long_err: err=%0b busy=%0b required 1/0",
                     load_err, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wimg !== cur || n_done != d0 || n_err != e0 + 1) begin
            failures++;
            $display("FAIL long_state: w=%h dn=%0d er=%0d required %h 0 1",
                     wimg, n_done - d0, n_err - e0, cur);
        end
    endtask

    task automatic test_idle_last;
        int e0;
        e0 = n_err;
        send_frame(fill(4'h4), 1, 0, 1'b0);
        checks++;
        if (load_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_last: err=%0b busy=%0b required 1/0",
                     load_err, busy);
        end
        @(negedge clk);
        checks++;
        if (wimg !== cur || n_err != e0 + 1) begin
            failures++;
            $display("FAIL idle_last_state: w=%h er=%0d required %h 1",
                     wimg, n_err - e0, cur);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = n_done;
        send_frame(fill(4'h7), 6, 99, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got %0b required 1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wimg !== INIT || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: w=%h busy=%0b ready=%0b required %h 0 0",
                     wimg, busy, in_ready, INIT);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || n_done != d0) begin
            failures++;
            $display("FAIL mid_release: ready=%0b dn=%0d required 1 0",
                     in_ready, n_done - d0);
        end
        cur = INIT;
        @(negedge clk);
        commit_frame(fill(4'h7), 1'b0, "after_rst");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_bubbled;
        test_short;
        test_long;
        test_idle_last;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simplenet_weight_loader.md
Name: simplenet_weight_loader

Overview:
- Writer side of the simpleNet weight interface. Accepts a valid/ready stream of signed weights, one weight per beat.
- Assembles the weights into a shadow bank and commits all nine weights to the active registers in a single cycle. simpleNet therefore never sees a partially updated weight set.
- Sits between the host/stimulus path and the simpleNet w0..w8 inputs.

Parameters:
- W_WIDTH, 4, bit width of each signed weight.
- INIT_W, 36'h1E2322122, reset image of the active weights, packed as {w8,w7,...,w0}, W_WIDTH bits each. The default decodes to w0..w8 = 2, 2, 1, 2, 2, 3, 2, -2, 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  W_WIDTH  signed weight. Beat k (0..8) targets wk.
- in_last  in  1  marks the final beat of a load frame.
- w0..w8  out  W_WIDTH each  signed active weights, wired to simpleNet.
- load_done  out  1  one-cycle pulse: a new weight set is active.
- load_err  out  1  one-cycle pulse: a malformed frame was discarded.
- busy  out  1  a frame is in progress (state is not IDLE).

Behaviour:
- Handshake
  - A beat is accepted on a rising edge where in_valid && in_ready.
  - in_data and in_last are sampled only on accepted beats.
  - Upstream holds in_valid, in_data and in_last stable until the beat is accepted.
- Reset (asynchronous, rst=1)
  - State = IDLE, idx = 0.
  - Shadow bank = INIT_W; w0..w8 = INIT_W slices.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after release.
  - load_done = 0, load_err = 0, busy = 0.
  - Reset mid-frame discards the frame. Active weights return to INIT_W, not to the last committed set.
- State machine: IDLE, LOAD, COMMIT, DRAIN.
  - IDLE
    - in_ready = 1.
    - Accepted beat: write shadow[0], set idx = 1, go to LOAD.
    - If that beat carries in_last: pulse load_err, stay in IDLE, leave shadow untouched.
  - LOAD
    - in_ready = 1.
    - Accepted beat: write shadow[idx].
    - idx == 8 with in_last: go to COMMIT.
    - idx < 8 with in_last (short frame): pulse load_err, go to IDLE, idx = 0.
    - idx == 8 without in_last (long frame): go to DRAIN.
    - Otherwise: idx = idx + 1.
  - COMMIT
    - Lasts exactly one cycle, with in_ready = 0.
    - On the closing edge: w0..w8 <= shadow, idx = 0, go to IDLE.
    - load_done is registered high in the cycle after COMMIT, which is the first cycle the new weights are visible.
  - DRAIN
    - in_ready = 1.
    - Accepted beats are discarded.
    - Accepted beat with in_last: pulse load_err, go to IDLE.
    - Active weights are unchanged.
- Error handling
  - On any error, the shadow contents are don't-care.
  - Active weights change only through COMMIT.
- Latency
  - Last beat accepted at edge N; state is COMMIT during cycle N..N+1.
  - Weights update at edge N+1; load_done is high for one cycle after edge N+1.
  - Minimum frame-to-frame spacing is 10 cycles: 9 beats plus 1 COMMIT cycle.
- Timing and width
  - load_err goes high for one cycle after the edge on which the error is detected.
  - load_err and load_done are never high together.
  - Weights are stored verbatim; there is no sign extension or saturation.
  - w7 = 4'b1110 is -2.

Test Plan:
- Reset, no traffic: w0..w8 = 2,2,1,2,2,3,2,-2,1; in_ready = 1; busy = 0; load_done = 0; load_err = 0.
- Back-to-back frame of 9 beats with in_valid held high, data 1..9, in_last on beat 9:
  - in_ready drops for exactly one cycle after beat 9.
  - w0..w8 = 1..9 and load_done pulses once, both one edge after the COMMIT cycle.
  - Total 10 cycles.
- Bubbled frame (in_valid toggles every other cycle), data -1 (4'b1111) on all beats: after commit, every weight is 4'b1111 and load_done pulses once.
- Short frame with in_last on beat 5: load_err pulses, w0..w8 unchanged, state IDLE. A following valid 9-beat frame commits normally.
- Long frame of 12 beats with in_last on beat 12:
  - Beats 10..12 are drained.
  - load_err pulses one cycle after beat 12; weights unchanged; load_done never asserts.
- rst asserted asynchronously after beat 6 of a frame loading 7s: outputs return to INIT_W without waiting for a clock edge, busy = 0, no load_done. After release, a new frame of 7s commits to all 7s.
